// File: rtl/tlb_mp.sv
// Multi-port LoongArch-style TLB: NUM entries and NPORT search ports with registered
// results, multi-hit flag, INVTLB with its own operands, round-robin TLBFILL and per-port counters.

module tlb_mp_port #(
  parameter int NUM = 16,
  parameter int IW  = $clog2(NUM)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    req,
  input  logic [18:0]             vppn,
  input  logic                    va_bit12,
  input  logic [9:0]              asid,
  input  logic [NUM-1:0]          t_e,
  input  logic [NUM-1:0]          t_g,
  input  logic [NUM-1:0]          t_ps4m,
  input  logic [NUM-1:0][18:0]    t_vppn,
  input  logic [NUM-1:0][9:0]     t_asid,
  input  logic [NUM-1:0][25:0]    t_pg0,
  input  logic [NUM-1:0][25:0]    t_pg1,
  output logic                    hit,
  output logic                    rsp_valid,
  output logic                    found,
  output logic                    multi,
  output logic [IW-1:0]           index,
  output logic [32:0]             pte
);
  logic [NUM-1:0] match;
  logic [IW-1:0]  idx;
  logic           sel;
  logic [25:0]    pg;
  logic [32:0]    pte_nxt;

  always_comb begin
    match = '0;
    idx   = '0;
    for (int i = 0; i < NUM; i++)
      match[i] = t_e[i] && (t_vppn[i][18:10] == vppn[18:10]) &&
                 (t_ps4m[i] || (t_vppn[i][9:0] == vppn[9:0])) &&
                 (t_g[i] || (t_asid[i] == asid));
    // scan downward so the lowest matching index is the one left in idx
    for (int i = NUM-1; i >= 0; i--)
      if (match[i]) idx = IW'(i);
  end

  assign hit     = |match;
  assign sel     = t_ps4m[idx] ? vppn[8] : va_bit12;
  assign pg      = sel ? t_pg1[idx] : t_pg0[idx];
  // page info is {ppn, plv, mat, d, v}; ps is re-expanded from the stored 4M flag
  assign pte_nxt = hit ? {1'b0, pg[25:6], (t_ps4m[idx] ? 6'd21 : 6'd12), pg[5:0]} : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      found     <= 1'b0;
      multi     <= 1'b0;
      index     <= '0;
      pte       <= '0;
    end else begin
      rsp_valid <= req;
      if (req) begin
        found <= hit;
        multi <= |(match & (match - 1'b1));
        index <= idx;
        pte   <= pte_nxt;
      end
    end
  end
endmodule

module tlb_mp #(
  parameter int NUM   = 16,
  parameter int NPORT = 2,
  localparam int IW   = $clog2(NUM)
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic [NPORT-1:0]            s_req,
  input  logic [NPORT-1:0][18:0]      s_vppn,
  input  logic [NPORT-1:0]            s_va_bit12,
  input  logic [NPORT-1:0][9:0]       s_asid,
  output logic [NPORT-1:0]            s_rsp_valid,
  output logic [NPORT-1:0]            s_found,
  output logic [NPORT-1:0]            s_multi,
  output logic [NPORT-1:0][IW-1:0]    s_index,
  output logic [NPORT-1:0][32:0]      s_pte,
  input  logic                        we,
  input  logic                        w_fill,
  input  logic [IW-1:0]               w_index,
  input  logic [88:0]                 w_entry,
  output logic [IW-1:0]               fill_ptr,
  input  logic [IW-1:0]               r_index,
  output logic [88:0]                 r_entry,
  input  logic                        inv_valid,
  input  logic [4:0]                  inv_op,
  input  logic [9:0]                  inv_asid,
  input  logic [18:0]                 inv_vppn,
  output logic                        inv_err,
  output logic [NPORT-1:0][31:0]      hit_cnt,
  output logic [NPORT-1:0][31:0]      miss_cnt
);
  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic [9:0]  asid;
    logic        g;
    logic [25:0] pg0;
    logic [25:0] pg1;
  } ent_t;

  ent_t                  w_ent;
  logic [NUM-1:0]        e_q, g_q, ps4m_q, inv_hit;
  logic [NUM-1:0][18:0]  vppn_q;
  logic [NUM-1:0][9:0]   asid_q;
  logic [NUM-1:0][25:0]  pg0_q, pg1_q;
  logic [IW-1:0]         w_tgt;
  logic [NPORT-1:0]      hit;
  logic [NPORT-1:0][31:0] hit_q, miss_q;

  assign w_ent = w_entry;
  assign w_tgt = w_fill ? fill_ptr : w_index;

  genvar p;
  generate
    for (p = 0; p < NPORT; p++) begin : g_port
      tlb_mp_port #(.NUM(NUM), .IW(IW)) u_port (
        .clk(clk), .rstn(rstn),
        .req(s_req[p]), .vppn(s_vppn[p]), .va_bit12(s_va_bit12[p]), .asid(s_asid[p]),
        .t_e(e_q), .t_g(g_q), .t_ps4m(ps4m_q), .t_vppn(vppn_q), .t_asid(asid_q),
        .t_pg0(pg0_q), .t_pg1(pg1_q),
        .hit(hit[p]), .rsp_valid(s_rsp_valid[p]), .found(s_found[p]), .multi(s_multi[p]),
        .index(s_index[p]), .pte(s_pte[p])
      );
    end
  endgenerate

  always_comb begin
    inv_hit = '0;
    for (int i = 0; i < NUM; i++) begin
      logic va, am;
      va = (vppn_q[i][18:10] == inv_vppn[18:10]) &&
           (ps4m_q[i] || (vppn_q[i][9:0] == inv_vppn[9:0]));
      am = (asid_q[i] == inv_asid);
      case (inv_op)
        5'd0, 5'd1: inv_hit[i] = 1'b1;
        5'd2:       inv_hit[i] = g_q[i];
        5'd3:       inv_hit[i] = !g_q[i];
        5'd4:       inv_hit[i] = !g_q[i] && am;
        5'd5:       inv_hit[i] = !g_q[i] && am && va;
        5'd6:       inv_hit[i] = (g_q[i] || am) && va;
        default:    inv_hit[i] = 1'b0;
      endcase
    end
  end

  // control state: e bits, fill pointer, error pulse
  always_ff @(posedge clk) begin
    if (!rstn) begin
      e_q      <= '0;
      fill_ptr <= '0;
      inv_err  <= 1'b0;
    end else begin
      inv_err <= inv_valid && (inv_op >= 5'd7);
      for (int i = 0; i < NUM; i++) begin
        if (we && (w_tgt == IW'(i)))      e_q[i] <= w_ent.e;
        else if (inv_valid && inv_hit[i]) e_q[i] <= 1'b0;
      end
      if (we && w_fill) fill_ptr <= fill_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      vppn_q[w_tgt] <= w_ent.vppn;
      ps4m_q[w_tgt] <= (w_ent.ps == 6'd21);
      asid_q[w_tgt] <= w_ent.asid;
      g_q[w_tgt]    <= w_ent.g;
      pg0_q[w_tgt]  <= w_ent.pg0;
      pg1_q[w_tgt]  <= w_ent.pg1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      for (int i = 0; i < NPORT; i++) begin
        if (s_req[i] && hit[i] && (hit_q[i] != '1))   hit_q[i]  <= hit_q[i] + 1'b1;
        if (s_req[i] && !hit[i] && (miss_q[i] != '1)) miss_q[i] <= miss_q[i] + 1'b1;
      end
    end
  end

  assign hit_cnt  = hit_q;
  assign miss_cnt = miss_q;
  assign r_entry  = {e_q[r_index], vppn_q[r_index], (ps4m_q[r_index] ? 6'd21 : 6'd12),
                     asid_q[r_index], g_q[r_index], pg0_q[r_index], pg1_q[r_index]};
endmodule

// File: tb/tb_tlb_mp.sv
// Directed bench for tlb_mp: search, multi-hit, INVTLB, TLBFILL wrap, collisions, saturation.

module tb_tlb_mp;
  localparam int NUM = 16, NPORT = 2, IW = 4;

  logic clk = 1'b0, rstn = 1'b0;
  logic [NPORT-1:0]          s_req = '0, s_va_bit12 = '0;
  logic [NPORT-1:0][18:0]    s_vppn = '0;
  logic [NPORT-1:0][9:0]     s_asid = '0;
  logic [NPORT-1:0]          s_rsp_valid, s_found, s_multi;
  logic [NPORT-1:0][IW-1:0]  s_index;
  logic [NPORT-1:0][32:0]    s_pte;
  logic we = 1'b0, w_fill = 1'b0;
  logic [IW-1:0] w_index = '0, r_index = '0, fill_ptr;
  logic [88:0]   w_entry = '0, r_entry;
  logic          inv_valid = 1'b0, inv_err;
  logic [4:0]    inv_op = '0;
  logic [9:0]    inv_asid = '0;
  logic [18:0]   inv_vppn = '0;
  logic [NPORT-1:0][31:0] hit_cnt, miss_cnt;

  int tests = 0, fails = 0;

  tlb_mp #(.NUM(NUM), .NPORT(NPORT)) dut (
    .clk(clk), .rstn(rstn), .s_req(s_req), .s_vppn(s_vppn), .s_va_bit12(s_va_bit12),
    .s_asid(s_asid), .s_rsp_valid(s_rsp_valid), .s_found(s_found), .s_multi(s_multi),
    .s_index(s_index), .s_pte(s_pte), .we(we), .w_fill(w_fill), .w_index(w_index),
    .w_entry(w_entry), .fill_ptr(fill_ptr), .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn),
    .inv_err(inv_err), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [88:0] obs, input logic [88:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [88:0] mk(input logic e, input logic [18:0] vppn, input logic [5:0] ps,
                                     input logic [9:0] asid, input logic g,
                                     input logic [19:0] ppn0, input logic v0,
                                     input logic [19:0] ppn1, input logic v1);
    return {e, vppn, ps, asid, g, ppn0, 5'b0, v0, ppn1, 5'b0, v1};
  endfunction

  function automatic logic [32:0] mkpte(input logic [19:0] ppn, input logic [5:0] ps, input logic v);
    return {1'b0, ppn, ps, 5'b0, v};
  endfunction

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic srch(input logic [18:0] v0, input logic b0, input logic [9:0] a0,
                      input logic [18:0] v1, input logic b1, input logic [9:0] a1);
    s_req = 2'b11;
    s_vppn[0] = v0; s_va_bit12[0] = b0; s_asid[0] = a0;
    s_vppn[1] = v1; s_va_bit12[1] = b1; s_asid[1] = a1;
    step();
    s_req = 2'b00;
  endtask

  task automatic wr(input logic fill, input logic [IW-1:0] idx, input logic [88:0] ent);
    we = 1'b1; w_fill = fill; w_index = idx; w_entry = ent;
    step();
    we = 1'b0; w_fill = 1'b0;
  endtask

  task automatic inv(input logic [4:0] op, input logic [9:0] asid, input logic [18:0] vppn);
    inv_valid = 1'b1; inv_op = op; inv_asid = asid; inv_vppn = vppn;
    step();
    inv_valid = 1'b0;
  endtask

  task automatic rd_e(input string tag, input logic [IW-1:0] idx, input logic exp);
    r_index = idx; #1;
    chk(tag, {88'b0, r_entry[88]}, {88'b0, exp});
  endtask

  initial begin
    // reset, with a search requested in the final reset cycle
    step();
    s_req = 2'b11; s_vppn = {19'h1, 19'h1};
    step();
    s_req = 2'b00;
    chk("rst_valid", {87'b0, s_rsp_valid}, 89'b0);
    chk("rst_found", {87'b0, s_found}, 89'b0);
    chk("rst_pte", {23'b0, s_pte}, 89'b0);
    chk("rst_fill_ptr", {85'b0, fill_ptr}, 89'b0);
    chk("rst_inv_err", {88'b0, inv_err}, 89'b0);
    chk("rst_hit_cnt", {25'b0, hit_cnt}, 89'b0);
    rstn = 1'b1;

    srch(19'h1, 1'b0, 10'h0, 19'h1, 1'b0, 10'h0);
    chk("empty_valid", {87'b0, s_rsp_valid}, 89'b11);
    chk("empty_found", {87'b0, s_found}, 89'b0);
    chk("empty_index", {81'b0, s_index}, 89'b0);
    chk("empty_pte", {23'b0, s_pte}, 89'b0);
    chk("empty_miss", {25'b0, miss_cnt}, {25'b0, 32'd1, 32'd1});
    step();
    chk("valid_one_cycle", {87'b0, s_rsp_valid}, 89'b0);

    // 4 KB entry, odd page
    wr(1'b0, 4'd3, mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h0, 1'b0, 20'hABCDE, 1'b1));
    r_index = 4'd3; #1;
    chk("rd_idx3", r_entry, mk(1'b1, 19'h12345, 6'd12, 10'd5, 1'b0, 20'h0, 1'b0, 20'hABCDE, 1'b1));
    srch(19'h12345, 1'b1, 10'd5, 19'h12345, 1'b1, 10'd6);
    chk("4k_found", {87'b0, s_found}, 89'b01);
    chk("4k_index", {85'b0, s_index[0]}, 89'd3);
    chk("4k_pte", {56'b0, s_pte[0]}, {56'b0, mkpte(20'hABCDE, 6'd12, 1'b1)});
    chk("4k_asid_miss_pte", {56'b0, s_pte[1]}, 89'b0);
    chk("4k_hit_cnt0", {57'b0, hit_cnt[0]}, 89'd1);
    chk("4k_miss_cnt1", {57'b0, miss_cnt[1]}, 89'd2);

    // 4 MB global entry, even page selected by vppn[8]
    wr(1'b0, 4'd7, mk(1'b1, 19'h12400, 6'd21, 10'd0, 1'b1, 20'h11111, 1'b1, 20'h22222, 1'b1));
    srch(19'h124FF, 1'b1, 10'd9, 19'h124FF, 1'b1, 10'd9);
    chk("4m_found", {87'b0, s_found}, 89'b11);
    chk("4m_index", {85'b0, s_index[1]}, 89'd7);
    chk("4m_multi", {87'b0, s_multi}, 89'b0);
    chk("4m_pte", {56'b0, s_pte[0]}, {56'b0, mkpte(20'h11111, 6'd21, 1'b1)});

    // overlapping 4 KB entry at a lower index; ps other than 21 reads back as 12
    wr(1'b0, 4'd2, mk(1'b1, 19'h124FF, 6'd14, 10'd9, 1'b0, 20'h33333, 1'b1, 20'h0, 1'b0));
    r_index = 4'd2; #1;
    chk("ps_readback_12", {83'b0, r_entry[68:63]}, 89'd12);
    srch(19'h124FF, 1'b0, 10'd9, 19'h124FF, 1'b0, 10'd9);
    chk("multi_index", {85'b0, s_index[0]}, 89'd2);
    chk("multi_flag", {87'b0, s_multi}, 89'b11);
    chk("multi_pte", {56'b0, s_pte[1]}, {56'b0, mkpte(20'h33333, 6'd12, 1'b1)});

    // INVTLB
    inv(5'd5, 10'd5, 19'h12345);
    chk("op5_no_err", {88'b0, inv_err}, 89'b0);
    rd_e("op5_e3", 4'd3, 1'b0);
    rd_e("op5_e7", 4'd7, 1'b1);
    rd_e("op5_e2", 4'd2, 1'b1);
    inv(5'd2, 10'd0, 19'h0);
    rd_e("op2_e7", 4'd7, 1'b0);
    rd_e("op2_e2", 4'd2, 1'b1);
    inv(5'd9, 10'd9, 19'h124FF);
    chk("op9_err", {88'b0, inv_err}, 89'b1);
    rd_e("op9_e2", 4'd2, 1'b1);
    step();
    chk("op9_err_pulse", {88'b0, inv_err}, 89'b0);

    // TLBFILL with an explicit write in the middle
    for (int i = 0; i < 6; i++)
      wr(1'b1, 4'd0, mk(1'b1, 19'h100 + 19'(i), 6'd12, 10'd1, 1'b0, 20'(i), 1'b1, 20'h0, 1'b0));
    wr(1'b0, 4'd10, mk(1'b1, 19'h7777, 6'd12, 10'd1, 1'b0, 20'h7, 1'b1, 20'h0, 1'b0));
    chk("explicit_keeps_ptr", {85'b0, fill_ptr}, 89'd6);
    for (int i = 6; i < NUM; i++)
      wr(1'b1, 4'd0, mk(1'b1, 19'h100 + 19'(i), 6'd12, 10'd1, 1'b0, 20'(i), 1'b1, 20'h0, 1'b0));
    chk("fill_wrap_ptr0", {85'b0, fill_ptr}, 89'd0);
    wr(1'b1, 4'd0, mk(1'b1, 19'h1FF, 6'd12, 10'd1, 1'b0, 20'h1FF, 1'b1, 20'h0, 1'b0));
    chk("fill_ptr_end", {85'b0, fill_ptr}, 89'd1);
    r_index = 4'd0; #1;
    chk("fill_idx0", {70'b0, r_entry[87:69]}, 89'h1FF);
    r_index = 4'd10; #1;
    chk("fill_idx10", {70'b0, r_entry[87:69]}, 89'h10A);
    r_index = 4'd15; #1;
    chk("fill_idx15", {70'b0, r_entry[87:69]}, 89'h10F);

    // write idx 4 and invalidate-all in the same cycle, with searches alongside
    we = 1'b1; w_fill = 1'b0; w_index = 4'd4;
    w_entry = mk(1'b1, 19'h2AAAA, 6'd12, 10'd1, 1'b0, 20'h44444, 1'b1, 20'h0, 1'b0);
    inv_valid = 1'b1; inv_op = 5'd0;
    srch(19'h2AAAA, 1'b0, 10'd1, 19'h105, 1'b0, 10'd1);
    we = 1'b0; inv_valid = 1'b0;
    chk("coll_old_miss", {88'b0, s_found[0]}, 89'b0);
    chk("coll_old_hit", {88'b0, s_found[1]}, 89'b1);
    chk("coll_old_idx", {85'b0, s_index[1]}, 89'd5);
    chk("coll_old_pte", {56'b0, s_pte[1]}, {56'b0, mkpte(20'h5, 6'd12, 1'b1)});
    rd_e("coll_e4", 4'd4, 1'b1);
    rd_e("coll_e5", 4'd5, 1'b0);
    rd_e("coll_e0", 4'd0, 1'b0);
    srch(19'h2AAAA, 1'b0, 10'd1, 19'h105, 1'b0, 10'd1);
    chk("coll_new_found", {87'b0, s_found}, 89'b01);
    chk("coll_new_idx", {85'b0, s_index[0]}, 89'd4);
    chk("coll_new_pte", {56'b0, s_pte[0]}, {56'b0, mkpte(20'h44444, 6'd12, 1'b1)});

    // counter saturation from a preset value
    dut.hit_q[0] = 32'hFFFF_FFFE;
    srch(19'h2AAAA, 1'b0, 10'd1, 19'h2AAAA, 1'b0, 10'd1);
    chk("sat_reach", {57'b0, hit_cnt[0]}, {57'b0, 32'hFFFF_FFFF});
    srch(19'h2AAAA, 1'b0, 10'd1, 19'h2AAAA, 1'b0, 10'd1);
    chk("sat_hold", {57'b0, hit_cnt[0]}, {57'b0, 32'hFFFF_FFFF});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
